// File: rtl/fu_alu_wb_queue.sv
// In-order writeback queue between the ALU and the shared writeback bus.
// Results to x0 are accepted but dropped; a flush empties the queue without clearing storage.
module fu_alu_wb_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned WORD_W = 32,
    parameter int unsigned REG_W  = 5
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       flush,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [WORD_W-1:0]          alu_result,
    input  logic [REG_W-1:0]           alu_rd,
    input  logic                       alu_negative,
    input  logic                       alu_overflow,
    input  logic                       alu_zero,
    output logic                       wb_valid,
    input  logic                       wb_ready,
    output logic [WORD_W-1:0]          wb_data,
    output logic [REG_W-1:0]           wb_rd,
    output logic [2:0]                 wb_flags,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned ENT_W = WORD_W + REG_W + 3;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [ENT_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [ENT_W-1:0] head;
    logic             enq, deq;

    assign alu_ready = (count_q != FULL);
    assign wb_valid  = (count_q != '0);
    assign count     = count_q;

    // x0 writes complete the handshake but never occupy a slot.
    assign enq = alu_valid & alu_ready & (alu_rd != '0) & ~flush;
    assign deq = wb_valid & wb_ready & ~flush;

    assign head     = mem_q[rd_ptr_q];
    assign wb_data  = head[ENT_W-1 -: WORD_W];
    assign wb_rd    = head[3 +: REG_W];
    assign wb_flags = head[2:0];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enq) begin
            mem_d[wr_ptr_q] = {alu_result, alu_rd, alu_negative, alu_overflow, alu_zero};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({enq, deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    a_count_bound : assert property (@(posedge CLK) disable iff (!nRST) count_q <= FULL);

endmodule

// File: tb/tb_fu_alu_wb_queue.sv
// Bench for fu_alu_wb_queue: directed vector table, hand-written corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_fu_alu_wb_queue;

    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        nRST, flush, alu_valid, alu_ready;
    logic [31:0] alu_result;
    logic [4:0]  alu_rd;
    logic        alu_negative, alu_overflow, alu_zero;
    logic        wb_valid, wb_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic [2:0]  wb_flags;
    logic [2:0]  count;

    fu_alu_wb_queue #(.DEPTH(DEPTH), .WORD_W(32), .REG_W(5)) dut (
        .CLK(CLK), .nRST(nRST), .flush(flush),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_result(alu_result),
        .alu_rd(alu_rd), .alu_negative(alu_negative), .alu_overflow(alu_overflow),
        .alu_zero(alu_zero), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_data(wb_data), .wb_rd(wb_rd), .wb_flags(wb_flags), .count(count)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, want);
    endtask

    task automatic set_in(input logic nr, input logic fl, input logic v, input logic [31:0] d,
                          input logic [4:0] rd, input logic [2:0] f, input logic wr);
        nRST = nr; flush = fl; alu_valid = v; alu_result = d; alu_rd = rd;
        {alu_negative, alu_overflow, alu_zero} = f; wb_ready = wr;
    endtask

    // Reference model: plain queue of {data, rd, flags}.
    typedef struct { logic [31:0] d; logic [4:0] rd; logic [2:0] f; } ent_t;
    ent_t model[$];

    // Checks the current outputs against the model, then applies inputs across one edge.
    task automatic step(input logic nr, input logic fl, input logic v, input logic [31:0] d,
                        input logic [4:0] rd, input logic [2:0] f, input logic wr);
        int sz;
        ent_t e;
        set_in(nr, fl, v, d, rd, f, wr);
        #1;
        sz = model.size();
        check("count", 32'(count), 32'(sz));
        check("wb_valid", 32'(wb_valid), 32'(sz != 0));
        check("alu_ready", 32'(alu_ready), 32'(sz != DEPTH));
        if (sz != 0) begin
            check("wb_data", wb_data, model[0].d);
            check("wb_rd", 32'(wb_rd), 32'(model[0].rd));
            check("wb_flags", 32'(wb_flags), 32'(model[0].f));
        end
        if (!nr || fl) begin
            model.delete();
        end else begin
            if (wr && sz != 0) void'(model.pop_front());
            if (v && sz != DEPTH && rd != 0) begin
                e.d = d; e.rd = rd; e.f = f;
                model.push_back(e);
            end
        end
        @(posedge CLK);
        #1;
    endtask

    typedef struct {
        logic nr, fl, v; logic [31:0] d; logic [4:0] rd; logic [2:0] f; logic wr;
        logic e_valid; logic [2:0] e_count; logic e_ready; logic chk;
        logic [31:0] e_data; logic [4:0] e_rd; logic [2:0] e_flags;
    } vec_t;

    vec_t vecs[8];

    initial begin
        // Expected values are outputs after the edge that applies the vector's inputs.
        vecs[0] = '{1'b0, 1'b0, 1'b1, 32'h11, 5'd1, 3'b111, 1'b0,
                    1'b0, 3'd0, 1'b1, 1'b1, 32'h0, 5'd0, 3'b000};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 32'h22, 5'd2, 3'b111, 1'b1,
                    1'b0, 3'd0, 1'b1, 1'b1, 32'h0, 5'd0, 3'b000};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 5'd7, 3'b100, 1'b1,
                    1'b1, 3'd1, 1'b1, 1'b1, 32'hDEADBEEF, 5'd7, 3'b100};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 32'h0, 5'd0, 3'b000, 1'b1,
                    1'b0, 3'd0, 1'b1, 1'b0, 32'h0, 5'd0, 3'b000};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 32'h99, 5'd0, 3'b001, 1'b0,
                    1'b0, 3'd0, 1'b1, 1'b0, 32'h0, 5'd0, 3'b000};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 32'h5, 5'd3, 3'b000, 1'b0,
                    1'b1, 3'd1, 1'b1, 1'b1, 32'h5, 5'd3, 3'b000};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 32'h0, 5'd0, 3'b000, 1'b0,
                    1'b1, 3'd1, 1'b1, 1'b1, 32'h5, 5'd3, 3'b000};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 32'h0, 5'd0, 3'b000, 1'b1,
                    1'b0, 3'd0, 1'b1, 1'b0, 32'h0, 5'd0, 3'b000};

        set_in(1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 3'b000, 1'b0);
        foreach (vecs[i]) begin
            set_in(vecs[i].nr, vecs[i].fl, vecs[i].v, vecs[i].d, vecs[i].rd, vecs[i].f,
                   vecs[i].wr);
            @(posedge CLK);
            #1;
            check($sformatf("vec%0d.wb_valid", i), 32'(wb_valid), 32'(vecs[i].e_valid));
            check($sformatf("vec%0d.count", i), 32'(count), 32'(vecs[i].e_count));
            check($sformatf("vec%0d.alu_ready", i), 32'(alu_ready), 32'(vecs[i].e_ready));
            if (vecs[i].chk) begin
                check($sformatf("vec%0d.wb_data", i), wb_data, vecs[i].e_data);
                check($sformatf("vec%0d.wb_rd", i), 32'(wb_rd), 32'(vecs[i].e_rd));
                check($sformatf("vec%0d.wb_flags", i), 32'(wb_flags), 32'(vecs[i].e_flags));
            end
        end

        // Model-tracked phases from here on; start from a known reset.
        step(1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 3'b000, 1'b0);

        // Fill with backpressure: rd=5 must be held until a slot frees.
        for (int i = 1; i <= 5; i++)
            step(1'b1, 1'b0, 1'b1, 32'h100 + 32'(i), 5'(i), 3'b010, 1'b0);
        check("fill.count", 32'(count), 32'd4);
        check("fill.alu_ready", 32'(alu_ready), 32'd0);
        check("fill.head_rd", 32'(wb_rd), 32'd1);
        step(1'b1, 1'b0, 1'b1, 32'h105, 5'd5, 3'b010, 1'b1);
        check("full_deq.count", 32'(count), 32'd3);
        for (int i = 0; i < 6; i++)
            step(1'b1, 1'b0, (i == 0), 32'h105, 5'd5, 3'b010, 1'b1);
        check("drain.count", 32'(count), 32'd0);

        // Simultaneous enqueue/dequeue at count=2 across pointer wrap.
        step(1'b1, 1'b0, 1'b1, 32'hA0, 5'd10, 3'b001, 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'hA1, 5'd11, 3'b001, 1'b0);
        for (int i = 0; i < 10; i++)
            step(1'b1, 1'b0, 1'b1, 32'hB0 + 32'(i), 5'(12 + i), 3'b000, 1'b1);
        check("simul.count", 32'(count), 32'd2);
        check("simul.head_rd", 32'(wb_rd), 32'd20);

        // Flush at count=3 with concurrent handshakes.
        step(1'b1, 1'b0, 1'b1, 32'hC0, 5'd4, 3'b000, 1'b0);
        check("pre_flush.count", 32'(count), 32'd3);
        step(1'b1, 1'b1, 1'b1, 32'hC1, 5'd6, 3'b000, 1'b1);
        check("flush.count", 32'(count), 32'd0);
        check("flush.wb_valid", 32'(wb_valid), 32'd0);

        // Reset mid-fill.
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, 1'b1, 32'hD0 + 32'(i), 5'(8 + i), 3'b000, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'hDF, 5'd9, 3'b000, 1'b1);
        check("reset_mid.count", 32'(count), 32'd0);
        check("reset_mid.wb_data", wb_data, 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic [4:0] r;
            r = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            step(($urandom_range(0, 99) != 0), ($urandom_range(0, 19) == 0),
                 1'($urandom), $urandom, r, 3'($urandom), 1'($urandom));
        end
        step(1'b1, 1'b0, 1'b0, 32'h0, 5'd0, 3'b000, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
